// File: rtl/hazard_bubble_ctrl_pkg.sv
// Shared definitions for the ID-stage hazard unit: control-bundle layout and FSM encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hazard_bubble_ctrl_pkg;

   // Control bundle width and field positions (LSB = branch).
   localparam int CTRL_W         = 10;
   localparam int CTRL_BRANCH    = 0;
   localparam int CTRL_MEM2REG   = 1;
   localparam int CTRL_REG_WRITE = 2;
   localparam int CTRL_MEM_WRITE = 3;
   localparam int CTRL_MEM_READ  = 4;
   localparam int CTRL_ALU_OP_LO = 5;
   localparam int CTRL_ALU_OP_HI = 7;
   localparam int CTRL_ALU_SRC   = 8;
   localparam int CTRL_REG_DST   = 9;

   // Hazard FSM encoding.
   typedef enum logic {
      HZ_IDLE  = 1'b0,
      HZ_STALL = 1'b1
   } hz_state_t;

endpackage

// File: rtl/hazard_bubble_ctrl_sat_counter.sv
// Saturating up-counter with enable and synchronous clear.
// Latency: count updates one clock after en is sampled.
// Backpressure: none; holds at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] count
);

   // Clear wins; otherwise step by one until all-ones is reached.
   always_ff @(posedge clk) begin
      if (clr) begin
         count <= '0;
      end else if (en && (count != {W{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/hazard_bubble_ctrl.sv
// ID-stage load-use hazard detection, bubble insertion, flush and freeze handling.
// Latency: bubble/enables are combinational (0 cycles); stall_active is decoded from the state register.
// Backpressure: ext_stall freezes PC and IF/ID and holds the stall countdown.
module hazard_bubble_ctrl #(
   parameter int CTRL_W            = hazard_bubble_ctrl_pkg::CTRL_W,
   parameter int REG_AW            = 5,
   parameter int LOAD_STALL_CYCLES = 1,
   parameter int CNT_W             = 16,
   parameter bit ZERO_REG_SKIP     = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_uses_rt,
   input  logic              ex_mem_read,
   input  logic [REG_AW-1:0] ex_rt,
   input  logic              flush,
   input  logic              ext_stall,
   input  logic [CTRL_W-1:0] ctrl_in,
   output logic [CTRL_W-1:0] ctrl_out,
   output logic              pc_write,
   output logic              if_id_write,
   output logic              bubble,
   output logic              stall_active,
   output logic [CNT_W-1:0]  stall_count
);

   import hazard_bubble_ctrl_pkg::*;

   // The first bubble is issued from IDLE, so STALL covers the remaining
   // LOAD_STALL_CYCLES-1 cycles: remain counts down from LOAD_STALL_CYCLES-2 to 0.
   localparam logic [3:0] REMAIN_INIT =
      4'((LOAD_STALL_CYCLES > 1) ? (LOAD_STALL_CYCLES - 2) : 0);

   hz_state_t  state;
   logic [3:0] remain;
   logic       ex_rt_live;
   logic       hazard;
   logic       in_stall;

   assign ex_rt_live = !ZERO_REG_SKIP || (ex_rt != '0);
   assign hazard     = ex_mem_read && ex_rt_live &&
                       ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
   assign in_stall   = (state == HZ_STALL);

   assign bubble       = flush || ext_stall || in_stall || hazard;
   assign ctrl_out     = bubble ? '0 : ctrl_in;
   // Flush keeps the front end moving so the branch target gets fetched,
   // unless the front end itself is frozen.
   assign pc_write     = flush ? !ext_stall : !bubble;
   assign if_id_write  = pc_write;
   assign stall_active = in_stall;

   // Stall sequencer: flush drops any pending stall; ext_stall holds the countdown.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= HZ_IDLE;
         remain <= '0;
      end else if (flush) begin
         state  <= HZ_IDLE;
         remain <= '0;
      end else begin
         case (state)
            HZ_IDLE: begin
               if (hazard && (LOAD_STALL_CYCLES > 1)) begin
                  state  <= HZ_STALL;
                  remain <= REMAIN_INIT;
               end
            end
            HZ_STALL: begin
               if (!ext_stall) begin
                  if (remain == 4'd0) begin
                     state <= HZ_IDLE;
                  end else begin
                     remain <= remain - 4'd1;
                  end
               end
            end
            default: begin
               state  <= HZ_IDLE;
               remain <= '0;
            end
         endcase
      end
   end

   sat_counter #(
      .W (CNT_W)
   ) u_bubble_cnt (
      .clk   (clk),
      .clr   (rst),
      .en    (bubble),
      .count (stall_count)
   );

endmodule

// File: tb/tb_hazard_bubble_ctrl.sv
// Self-checking bench: three hazard units (LOAD_STALL_CYCLES 1/3/4, one with a 4-bit counter)
// share one directed stimulus stream and are compared every cycle against a behavioural model.
// The model tracks "bubbles still owed" per unit rather than any FSM state.
module tb_hazard_bubble_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
   logic       id_uses_rt = 1'b0, ex_mem_read = 1'b0, flush = 1'b0, ext_stall = 1'b0;
   logic [9:0] ctrl_in = 10'h3FF;

   logic [9:0]  co [3];
   logic        pw [3], iw [3], bb [3], sa [3];
   logic [15:0] sc [3];
   logic [3:0]  sc_b;
   assign sc[1] = {12'd0, sc_b};

   int pass_cnt = 0;
   int total_cnt = 0;

   localparam int LSC  [3] = '{1, 3, 4};
   localparam int MAXC [3] = '{65535, 15, 65535};
   int left [3] = '{0, 0, 0};
   int mcnt [3] = '{0, 0, 0};

   always #5 clk = ~clk;

   hazard_bubble_ctrl #(.LOAD_STALL_CYCLES(1), .CNT_W(16)) u_a (
      .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .flush(flush), .ext_stall(ext_stall),
      .ctrl_in(ctrl_in), .ctrl_out(co[0]), .pc_write(pw[0]), .if_id_write(iw[0]),
      .bubble(bb[0]), .stall_active(sa[0]), .stall_count(sc[0]));

   hazard_bubble_ctrl #(.LOAD_STALL_CYCLES(3), .CNT_W(4)) u_b (
      .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .flush(flush), .ext_stall(ext_stall),
      .ctrl_in(ctrl_in), .ctrl_out(co[1]), .pc_write(pw[1]), .if_id_write(iw[1]),
      .bubble(bb[1]), .stall_active(sa[1]), .stall_count(sc_b));

   hazard_bubble_ctrl #(.LOAD_STALL_CYCLES(4), .CNT_W(16)) u_c (
      .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .flush(flush), .ext_stall(ext_stall),
      .ctrl_in(ctrl_in), .ctrl_out(co[2]), .pc_write(pw[2]), .if_id_write(iw[2]),
      .bubble(bb[2]), .stall_active(sa[2]), .stall_count(sc[2]));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic logic m_hazard();
      return ex_mem_read && (ex_rt != 5'd0) &&
             ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
   endfunction

   function automatic logic m_bubble(input int i);
      return flush || ext_stall || (left[i] > 0) || m_hazard();
   endfunction

   // Model state advance: bubbles owed after a hazard, held by ext_stall, cancelled by flush.
   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (rst) begin
            left[i] = 0;
            mcnt[i] = 0;
         end else begin
            if (m_bubble(i) && mcnt[i] < MAXC[i]) mcnt[i] = mcnt[i] + 1;
            if (flush) left[i] = 0;
            else if (left[i] > 0) begin
               if (!ext_stall) left[i] = left[i] - 1;
            end else if (m_hazard()) left[i] = LSC[i] - 1;
         end
      end
   end

   // Every-cycle comparison of all outputs of all three units.
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         logic b, p;
         b = m_bubble(i);
         p = flush ? !ext_stall : !b;
         check($sformatf("u%0d.bubble", i), {31'd0, bb[i]}, {31'd0, b});
         check($sformatf("u%0d.ctrl_out", i), {22'd0, co[i]}, b ? 32'd0 : {22'd0, ctrl_in});
         check($sformatf("u%0d.pc_write", i), {31'd0, pw[i]}, {31'd0, p});
         check($sformatf("u%0d.if_id_write", i), {31'd0, iw[i]}, {31'd0, p});
         check($sformatf("u%0d.stall_active", i), {31'd0, sa[i]}, {31'd0, (left[i] > 0)});
         check($sformatf("u%0d.stall_count", i), {16'd0, sc[i]}, mcnt[i]);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic load_use(input logic [4:0] r);
      ex_mem_read = 1'b1; ex_rt = r; id_rs = r;
   endtask

   initial begin
      step(); step();
      rst = 1'b0;
      #2;
      check("reset pc_write", {31'd0, pw[0]}, 32'd1);
      check("reset bubble", {31'd0, bb[1]}, 32'd0);
      check("reset stall_active", {31'd0, sa[2]}, 32'd0);
      check("reset ctrl_out", {22'd0, co[0]}, 32'h3FF);

      // Load-use on rs
      load_use(5'd8);
      #2;
      check("lu ctrl_out zero", {22'd0, co[0]}, 32'd0);
      check("lu pc_write", {31'd0, pw[0]}, 32'd0);
      check("lu if_id_write", {31'd0, iw[0]}, 32'd0);
      check("lu bubble", {31'd0, bb[0]}, 32'd1);
      step();
      ex_mem_read = 1'b0;
      #2;
      check("lu ctrl_out restored", {22'd0, co[0]}, 32'h3FF);
      check("lu stall_count", {16'd0, sc[0]}, 32'd1);
      check("ms3 stall_active c2", {31'd0, sa[1]}, 32'd1);
      step(); #2;
      check("ms3 stall_active c3", {31'd0, sa[1]}, 32'd1);
      step(); #2;
      check("ms3 idle after 3", {31'd0, sa[1]}, 32'd0);
      check("ms3 bubble count", {16'd0, sc[1]}, 32'd3);
      check("model ms3 count", mcnt[1], 32'd3);
      step(); step();

      // Register 0 and unused-rt filtering
      do_reset();
      ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
      #2;
      check("zero reg no bubble", {31'd0, bb[0]}, 32'd0);
      ex_rt = 5'd9; id_rt = 5'd9; id_rs = 5'd3; id_uses_rt = 1'b0;
      #2;
      check("rt unused no bubble", {31'd0, bb[0]}, 32'd0);
      id_uses_rt = 1'b1;
      #2;
      check("rt used bubble", {31'd0, bb[0]}, 32'd1);
      ex_mem_read = 1'b0; id_uses_rt = 1'b0;
      step(); #2;
      check("filter count", {16'd0, sc[0]}, 32'd0);

      // ext_stall extends a 3-cycle stall to 5
      do_reset();
      load_use(5'd8);
      step();
      ex_mem_read = 1'b0; ext_stall = 1'b1;
      step(); step();
      ext_stall = 1'b0;
      repeat (4) step();
      #2;
      check("ext ms3 bubbles", {16'd0, sc[1]}, 32'd5);
      check("ext lsc1 bubbles", {16'd0, sc[0]}, 32'd3);
      check("model ext ms4", mcnt[2], 32'd6);

      // Flush in the second bubble of a 4-cycle stall
      do_reset();
      load_use(5'd8);
      step();
      ex_mem_read = 1'b0; flush = 1'b1;
      #2;
      check("flush pc_write", {31'd0, pw[2]}, 32'd1);
      check("flush bubble", {31'd0, bb[2]}, 32'd1);
      check("flush ctrl_out", {22'd0, co[2]}, 32'd0);
      step();
      flush = 1'b0;
      #2;
      check("flush idle", {31'd0, sa[2]}, 32'd0);
      check("flush no bubble", {31'd0, bb[2]}, 32'd0);
      check("flush total", {16'd0, sc[2]}, 32'd2);

      // Reset in the middle of a stall
      load_use(5'd8);
      step();
      ex_mem_read = 1'b0; rst = 1'b1;
      step();
      rst = 1'b0;
      #2;
      check("rst stall_active", {31'd0, sa[2]}, 32'd0);
      check("rst stall_count", {16'd0, sc[2]}, 32'd0);
      check("rst pc_write", {31'd0, pw[2]}, 32'd1);

      // Hazard + flush + ext_stall in IDLE: frozen, no STALL entry
      load_use(5'd8); flush = 1'b1; ext_stall = 1'b1;
      #2;
      check("fl+ext pc_write", {31'd0, pw[2]}, 32'd0);
      check("fl+ext if_id_write", {31'd0, iw[2]}, 32'd0);
      check("fl+ext bubble", {31'd0, bb[2]}, 32'd1);
      step();
      ex_mem_read = 1'b0; flush = 1'b0; ext_stall = 1'b0;
      #2;
      check("fl+hz no stall", {31'd0, sa[2]}, 32'd0);

      // Saturation of the 4-bit counter
      do_reset();
      ext_stall = 1'b1;
      repeat (20) step();
      ext_stall = 1'b0;
      #2;
      check("sat 4-bit", {16'd0, sc[1]}, 32'hF);
      check("sat 16-bit", {16'd0, sc[0]}, 32'd20);
      step();

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
